uart_tx_fifo: RTL and testbench

//  - Byte buffer and launcher that sits directly upstream of UART_TX.
//  - Accepts bytes from a producer at up to one byte per clock and stores them in a FIFO.
//  - Feeds the bytes to UART_TX one at a time through its i_TX_DV / i_TX_Byte inputs.
//  - Uses UART_TX's o_TX_Active / o_TX_Done to pace transfers, so producers never have to

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo_if.sv | 37 +++
 rtl/sync_fifo_ram.sv | 31 +++
 rtl/uart_tx_fifo.sv | 142 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the launcher FSM state encoding.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACT,
        WAIT_DONE,
        GAP
    } tx_fifo_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_if.sv
// Producer-side and UART_TX-side signals of the byte launcher.
// The launcher connects through the slave modport. The producer plus UART_TX
// (or a bench) connects through the master modport.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
);

    // Producer side
    logic                   i_Wr_DV;
    logic [UART_BYTE_W-1:0] i_Wr_Byte;
    logic                   o_Full;
    logic                   o_Empty;
    logic [AW:0]            o_Count;
    logic                   o_Overflow;
    logic                   i_Clr_Ovf;

    // UART_TX side
    logic                   o_TX_DV;
    logic [UART_BYTE_W-1:0] o_TX_Byte;
    logic                   i_TX_Active;
    logic                   i_TX_Done;
    logic                   o_Busy;

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_Clr_Ovf, i_TX_Active, i_TX_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte, o_Busy
    );

    modport master (
        output i_Wr_DV, i_Wr_Byte, i_Clr_Ovf, i_TX_Active, i_TX_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte, o_Busy
    );

endinterface : uart_tx_fifo_if

// File: rtl/sync_fifo_ram.sv
// DEPTH x W storage for the launcher FIFO.
// It has one synchronous write port and one combinational read port.
module sync_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = UART_BYTE_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Store the incoming byte at the write pointer.
    // NOTE: the array deliberately has no reset. The pointers and count define which entries are valid,
    // and leaving the storage unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : sync_fifo_ram

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launcher placed upstream of UART_TX.
// It queues producer bytes and hands them to UART_TX one frame at a time.
// Each hand-off is paced by UART_TX's active and done handshakes.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic           CLK,
    input logic           RST_N,
    uart_tx_fifo_if.slave bus
);

    // Pointers, occupancy and sticky overflow flag
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   ovf_q, ovf_d;

    // Launcher FSM and its registered outputs
    tx_fifo_state_t         state_q, state_d;
    logic                   tx_dv_q, tx_dv_d;
    logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;

    logic                   full;
    logic                   empty;
    logic                   wr_accept;
    logic                   wr_drop;
    logic                   pop;
    logic [UART_BYTE_W-1:0] rd_data;

    // Full and empty come from the registered count.
    // A write in the same cycle as a pop is still dropped when the FIFO is full.
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign wr_accept = bus.i_Wr_DV && !full;
    assign wr_drop   = bus.i_Wr_DV && full;

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (UART_BYTE_W)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (wr_accept),
        .wr_addr (wptr_q),
        .wr_data (bus.i_Wr_Byte),
        .rd_addr (rptr_q),
        .rd_data (rd_data)
    );

    // Launcher next-state and output logic.
    // A pop happens only on the IDLE->LAUNCH transition.
    // NOTE: every signal gets a default before the case statement, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d   = LAUNCH;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = rd_data;
                    pop       = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT_ACT;
            end
            WAIT_ACT: begin
                // A frame short enough to finish before Active is seen still ends cleanly.
                if (bus.i_TX_Done) begin
                    state_d = GAP;
                end else if (bus.i_TX_Active) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.i_TX_Done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer, count and overflow-flag updates.
    // When a write is dropped in the same cycle as a clear, setting the flag wins.
    always_comb begin
        wptr_d  = wptr_q + AW'(wr_accept);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(wr_accept) - (AW+1)'(pop);
        ovf_d   = ovf_q;
        if (wr_drop) begin
            ovf_d = 1'b1;
        end else if (bus.i_Clr_Ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State register.
    // Reset discards queued bytes and abandons any frame in flight.
    // NOTE: use non-blocking assignments for every flop, so that all of them sample their
    // pre-edge inputs together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign bus.o_Full     = full;
    assign bus.o_Empty    = empty;
    assign bus.o_Count    = count_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_TX_DV    = tx_dv_q;
    assign bus.o_TX_Byte  = tx_byte_q;
    assign bus.o_Busy     = (state_q != IDLE);

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo.
// A behavioural UART_TX stand-in drives Active and Done and logs every launched byte.
// A queue-based occupancy model checks count, flags and launch order on every cycle.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int CPB   = 4;           // shortened bit time keeps the run small
    localparam int FRAME = 10 * CPB;    // start + 8 data + stop

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   cyc   = 0;

    int n_checks = 0;
    int n_pass   = 0;

    always #20 CLK = ~CLK;              // 25 MHz
    always @(posedge CLK) cyc <= cyc + 1;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Reference model state
    logic [7:0] model_q [$];            // bytes stored and not yet launched
    logic [7:0] rx_q    [$];            // bytes handed to the UART, in launch order
    logic       exp_ovf;
    logic [7:0] exp_byte;
    int         done_cyc;
    logic       done_nonempty;
    logic       short_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // UART_TX stand-in.
    // A launch seen after edge K raises Active after edge K+1.
    // Done pulses for one cycle when the frame ends.
    // In short mode the frame completes with Done only and Active never rises.
    initial begin : uart_model
        int  busy_cnt;
        logic launch_pend;
        busy_cnt        = 0;
        launch_pend     = 1'b0;
        done_cyc        = -1;
        done_nonempty   = 1'b0;
        bus.i_TX_Active = 1'b0;
        bus.i_TX_Done   = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            bus.i_TX_Done = 1'b0;
            if (!RST_N) begin
                bus.i_TX_Active = 1'b0;
                busy_cnt        = 0;
                launch_pend     = 1'b0;
            end else begin
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        bus.i_TX_Active = 1'b0;
                        bus.i_TX_Done   = 1'b1;
                        done_cyc        = cyc;
                        done_nonempty   = (model_q.size() > 0);
                    end
                end else if (launch_pend) begin
                    launch_pend = 1'b0;
                    busy_cnt    = short_mode ? 2 : FRAME;
                    if (!short_mode) bus.i_TX_Active = 1'b1;
                end
                if (bus.o_TX_DV) begin
                    launch_pend = 1'b1;
                    rx_q.push_back(bus.o_TX_Byte);
                end
            end
        end
    end

    // Occupancy model, checked on every falling edge.
    // It applies the previous rising edge's write and pop and compares all producer-visible state.
    initial begin : monitor
        logic       prev_wr, prev_clr, prev_dv, drop;
        logic [7:0] prev_wbyte;
        prev_wr    = 1'b0;
        prev_clr   = 1'b0;
        prev_dv    = 1'b0;
        prev_wbyte = '0;
        exp_ovf    = 1'b0;
        exp_byte   = '0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                model_q.delete();
                exp_ovf  = 1'b0;
                exp_byte = '0;
                prev_wr  = 1'b0;
                prev_clr = 1'b0;
                prev_dv  = 1'b0;
                done_cyc = -1;
            end else begin
                // Full is judged on the occupancy before the edge, before any pop.
                drop = prev_wr && (model_q.size() == DEPTH);
                if (bus.o_TX_DV) begin
                    check("dv_single_cycle", 32'(prev_dv), 0);
                    check("pop_from_nonempty", 32'(model_q.size() > 0), 1);
                    if (model_q.size() > 0) exp_byte = model_q.pop_front();
                    check("launch_byte", 32'(bus.o_TX_Byte), 32'(exp_byte));
                    // Done is sampled at edge E, and the relaunch lands on edge E+2.
                    if (done_cyc >= 0 && done_nonempty)
                        check("relaunch_latency", 32'(cyc - done_cyc), 3);
                    done_cyc = -1;
                end else begin
                    check("tx_byte_hold", 32'(bus.o_TX_Byte), 32'(exp_byte));
                end
                if (prev_wr && !drop) model_q.push_back(prev_wbyte);
                if (drop) exp_ovf = 1'b1;
                else if (prev_clr) exp_ovf = 1'b0;
                check("count", 32'(bus.o_Count), 32'(model_q.size()));
                check("empty", 32'(bus.o_Empty), 32'(model_q.size() == 0));
                check("full", 32'(bus.o_Full), 32'(model_q.size() == DEPTH));
                check("overflow", 32'(bus.o_Overflow), 32'(exp_ovf));
                prev_dv    = bus.o_TX_DV;
                prev_wr    = bus.i_Wr_DV;
                prev_clr   = bus.i_Clr_Ovf;
                prev_wbyte = bus.i_Wr_Byte;
            end
        end
    end

    // Watchdog: no test step may hang the run.
    initial begin
        #3000000;
        $display("FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((!bus.o_Empty || bus.o_Busy) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 3000), 1);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp_list [$]);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_list.size()));
        for (int i = 0; i < exp_list.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(rx_q[i]), 32'(exp_list[i]));
    endtask

    initial begin : stimulus
        logic [7:0] exp_list [$];
        int         peak;
        int         n;
        short_mode      = 1'b0;
        bus.i_Wr_DV     = 1'b0;
        bus.i_Wr_Byte   = '0;
        bus.i_Clr_Ovf   = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_dv", 32'(bus.o_TX_DV), 0);
        check("rst_byte", 32'(bus.o_TX_Byte), 0);
        check("rst_ovf", 32'(bus.o_Overflow), 0);
        check("rst_busy", 32'(bus.o_Busy), 0);
        check("rst_empty", 32'(bus.o_Empty), 1);
        check("rst_full", 32'(bus.o_Full), 0);
        check("rst_count", 32'(bus.o_Count), 0);
        RST_N = 1'b1;
        tick();

        // 1. Single byte: written at edge N, o_TX_DV is high in the cycle after edge N+1
        bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = 8'h3A;
        tick();
        bus.i_Wr_DV = 1'b0;
        check("t1_dv_n", 32'(bus.o_TX_DV), 0);
        check("t1_count_n", 32'(bus.o_Count), 1);
        tick();
        check("t1_dv_n1", 32'(bus.o_TX_DV), 1);
        check("t1_byte", 32'(bus.o_TX_Byte), 32'h3A);
        check("t1_empty", 32'(bus.o_Empty), 1);
        check("t1_busy", 32'(bus.o_Busy), 1);
        tick();
        check("t1_dv_n2", 32'(bus.o_TX_DV), 0);
        wait_drain("t1_drain");
        check_rx("t1_rx", '{8'h3A});
        rx_q.delete();

        // 2. Burst of three back-to-back writes
        peak = 0;
        exp_list = '{8'h3A, 8'h55, 8'hA5};
        bus.i_Wr_DV = 1'b1;
        foreach (exp_list[i]) begin
            bus.i_Wr_Byte = exp_list[i];
            tick();
            if (int'(bus.o_Count) > peak) peak = int'(bus.o_Count);
        end
        bus.i_Wr_DV = 1'b0;
        check("t2_peak", 32'(peak), 2);
        wait_drain("t2_drain");
        check_rx("t2_rx", exp_list);
        rx_q.delete();

        // 3. Overflow: 18 consecutive writes 00..11 and 8'h11 is dropped
        bus.i_Wr_DV = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.i_Wr_Byte = 8'(i);
            tick();
            if (i == 16) begin
                check("t3_full_at16", 32'(bus.o_Full), 1);
                check("t3_count_at16", 32'(bus.o_Count), 16);
                check("t3_ovf_before", 32'(bus.o_Overflow), 0);
            end
        end
        bus.i_Wr_DV = 1'b0;
        check("t3_ovf_set", 32'(bus.o_Overflow), 1);
        check("t3_count_after", 32'(bus.o_Count), 16);
        tick();
        check("t3_ovf_sticky", 32'(bus.o_Overflow), 1);
        bus.i_Clr_Ovf = 1'b1;
        tick();
        bus.i_Clr_Ovf = 1'b0;
        check("t3_ovf_clr", 32'(bus.o_Overflow), 0);
        wait_drain("t3_drain");
        exp_list.delete();
        for (int i = 0; i < 17; i++) exp_list.push_back(8'(i));
        check_rx("t3_rx", exp_list);
        rx_q.delete();

        // 4. Wrap-around: 3 rounds of 12 random bytes with random gaps.
        // Round 2 uses frames that finish without an Active phase.
        exp_list.delete();
        for (int r = 0; r < 3; r++) begin
            short_mode = (r == 1);
            for (int i = 0; i < 12; i++) begin
                bus.i_Wr_DV   = 1'b1;
                bus.i_Wr_Byte = 8'($urandom);
                exp_list.push_back(bus.i_Wr_Byte);
                tick();
                bus.i_Wr_DV = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_drain($sformatf("t4_drain_r%0d", r));
        end
        short_mode = 1'b0;
        check_rx("t4_rx", exp_list);
        rx_q.delete();

        // 5. Reset in the 4th data bit with 5 bytes queued
        bus.i_Wr_DV = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.i_Wr_Byte = 8'hB0 + 8'(i);
            tick();
        end
        bus.i_Wr_DV = 1'b0;
        n = 0;
        while (!bus.i_TX_Active && n < 50) begin
            tick();
            n++;
        end
        check("t5_active_seen", 32'(n < 50), 1);
        repeat (4 * CPB + 1) tick();
        check("t5_queued", 32'(bus.o_Count), 5);
        RST_N = 1'b0;
        #2;
        check("t5_rst_dv", 32'(bus.o_TX_DV), 0);
        check("t5_rst_byte", 32'(bus.o_TX_Byte), 0);
        check("t5_rst_ovf", 32'(bus.o_Overflow), 0);
        check("t5_rst_busy", 32'(bus.o_Busy), 0);
        check("t5_rst_empty", 32'(bus.o_Empty), 1);
        check("t5_rst_full", 32'(bus.o_Full), 0);
        check("t5_rst_count", 32'(bus.o_Count), 0);
        repeat (3) tick();
        RST_N = 1'b1;
        repeat (20) tick();
        check("t5_no_relaunch", 32'(rx_q.size()), 1);
        check("t5_idle", 32'(bus.o_Busy), 0);
        rx_q.delete();
        bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = 8'hC3;
        tick();
        bus.i_Wr_DV = 1'b0;
        wait_drain("t5_drain");
        check_rx("t5_rx", '{8'hC3});
        rx_q.delete();

        // 6. Accepted write on the same edge as IDLE->LAUNCH with count=1
        bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = 8'hA1;
        tick();
        bus.i_Wr_Byte = 8'h77;
        tick();
        bus.i_Wr_DV = 1'b0;
        check("t6_count", 32'(bus.o_Count), 1);
        check("t6_dv", 32'(bus.o_TX_DV), 1);
        check("t6_byte", 32'(bus.o_TX_Byte), 32'hA1);
        wait_drain("t6_drain");
        check_rx("t6_rx", '{8'hA1, 8'h77});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_tx_fifo
